// File: rtl/ser_link_pkg.sv
// rtl/ser_link_pkg.sv - shared types and defaults for the serial link scheduler
package ser_link_pkg;

   localparam int BYTE_W         = 8;
   localparam int DEF_NREQ       = 4;
   localparam int DEF_GAP_CYCLES = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

endpackage

// File: rtl/ser_link_sched_rr_arbiter.sv
// rtl/ser_link_sched_rr_arbiter.sv - round-robin pick searching from last_grant+1
module rr_arbiter
   import ser_link_pkg::*;
#(
   parameter int N  = DEF_NREQ,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      // last_grant itself is checked last, so a lone requester always wins
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last_grant) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/ser_link_sched.sv
// rtl/ser_link_sched.sv - arbitrates byte requesters onto an MSB-first serial link
module ser_link_sched
   import ser_link_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic                     clka,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [BYTE_W*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     wra_n,
   output logic                     da,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  cur_id
);

   localparam int IW = $clog2(NREQ);
   localparam int GW = $clog2(GAP_CYCLES);

   state_t              state, state_d;
   logic [2:0]          bit_cnt;
   logic [GW-1:0]       gap_cnt;
   logic [BYTE_W-1:0]   shreg;
   logic [BYTE_W-1:0]   win_byte;
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       cur_id_q;
   logic [NREQ-1:0]     grant;
   logic [IW-1:0]       grant_idx;
   logic                wra_n_q;
   logic                da_q;
   logic                handshake;
   logic                gap_last;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign req_ready = (state == ST_IDLE) ? grant : '0;
   assign handshake = (state == ST_IDLE) && (|req_valid);
   assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));
   assign busy      = (state != ST_IDLE);
   assign wra_n     = wra_n_q;
   assign da        = da_q;
   assign cur_id    = cur_id_q;

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) win_byte = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:  if (handshake)        state_d = ST_SHIFT;
         ST_SHIFT: if (bit_cnt == 3'd7)  state_d = ST_GAP;
         ST_GAP:   if (gap_last)         state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // bit 7 goes straight to da on the handshake edge; shreg holds the rest
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         shreg      <= '0;
         last_grant <= IW'(NREQ - 1);
         cur_id_q   <= '0;
         wra_n_q    <= 1'b1;
         da_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  shreg      <= {win_byte[BYTE_W-2:0], 1'b0};
                  da_q       <= win_byte[BYTE_W-1];
                  wra_n_q    <= 1'b0;
                  last_grant <= grant_idx;
                  cur_id_q   <= grant_idx;
               end
            end
            ST_SHIFT: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  wra_n_q <= 1'b1;
                  da_q    <= 1'b0;
               end else begin
                  da_q  <= shreg[BYTE_W-1];
                  shreg <= {shreg[BYTE_W-2:0], 1'b0};
               end
            end
            ST_GAP: begin
               gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ser_link_sched.sv
// tb/tb_ser_link_sched.sv - self-checking bench for ser_link_sched with receiver scoreboard
module tb_ser_link_sched;

   localparam int NREQ = 4;
   localparam int G    = 6;

   logic                clka = 1'b0;
   logic                clkb = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [8*NREQ-1:0]   req_data = '0;
   logic [NREQ-1:0]     req_ready;
   logic                wra_n;
   logic                da;
   logic                busy;
   logic [1:0]          cur_id;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ser_link_sched #(.NREQ(NREQ), .GAP_CYCLES(G)) dut (
      .clka      (clka),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wra_n     (wra_n),
      .da        (da),
      .busy      (busy),
      .cur_id    (cur_id)
   );

   always #50 clka = ~clka;
   always #38 clkb = ~clkb;
   always @(posedge clka) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step;
      @(posedge clka);
      #1;
   endtask

   // Timeline model: a handshake at cycle T owns T+1..T+8 (bits) and T+9..T+8+G (gap)
   int              m_last, m_cur, m_free, m_hs, m_wi, m_d;
   logic [7:0]      m_byte;
   logic [NREQ-1:0] exp_ready;
   logic            exp_wra, exp_da;
   logic [NREQ-1:0] hs_mask = '0;
   logic [7:0]      sent_q[$];

   always @(negedge clka) begin
      if (!rst_n) begin
         m_last = NREQ - 1;
         m_cur  = 0;
         m_free = 0;
         m_hs   = -1000;
         hs_mask = '0;
         sent_q.delete();
         chk("rst_ready", 32'(req_ready), 0);
         chk("rst_wra_n", 32'(wra_n), 1);
         chk("rst_da",    32'(da), 0);
         chk("rst_busy",  32'(busy), 0);
         chk("rst_cur_id", 32'(cur_id), 0);
      end else begin
         exp_ready = '0;
         m_wi = 0;
         if (cyc >= m_free) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (exp_ready == '0 && req_valid[(m_last + k) % NREQ]) begin
                  m_wi = (m_last + k) % NREQ;
                  exp_ready[m_wi] = 1'b1;
               end
            end
         end
         m_d = cyc - m_hs;
         exp_wra = !(m_d >= 1 && m_d <= 8);
         exp_da  = exp_wra ? 1'b0 : m_byte[3'(8 - m_d)];
         chk("m_ready",  32'(req_ready), 32'(exp_ready));
         chk("m_wra_n",  32'(wra_n), 32'(exp_wra));
         chk("m_da",     32'(da), 32'(exp_da));
         chk("m_busy",   32'(busy), 32'(cyc < m_free));
         chk("m_cur_id", 32'(cur_id), 32'(m_cur));
         hs_mask = req_valid & req_ready;
         if (exp_ready != '0) begin
            m_hs   = cyc;
            m_byte = req_data[m_wi*8 +: 8];
            m_last = m_wi;
            m_cur  = m_wi;
            m_free = cyc + 9 + G;
            sent_q.push_back(m_byte);
         end
      end
   end

   // Downstream receiver: bit capture on the link clock, frame-end seen through a 3-flop sync on clkb
   logic [7:0] rx_sh, rx_hold;
   logic       wra_d;
   logic [3:0] syn;
   int         rx_count = 0;

   always @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh   <= '0;
         rx_hold <= '0;
         wra_d   <= 1'b1;
      end else begin
         wra_d <= wra_n;
         if (!wra_n) rx_sh <= {rx_sh[6:0], da};
         if (wra_n && !wra_d) rx_hold <= rx_sh;
      end
   end

   always @(posedge clkb or negedge rst_n) begin
      if (!rst_n) begin
         syn      <= 4'hF;
         rx_count <= 0;
      end else begin
         syn <= {syn[2:0], wra_n};
         if (syn[2] && !syn[3]) begin
            if (sent_q.size() == 0) chk("rx_extra_frame", 32'(sent_q.size()), 1);
            else                    chk("rx_byte", 32'(rx_hold), 32'(sent_q.pop_front()));
            rx_count <= rx_count + 1;
         end
      end
   end

   task automatic do_reset;
      req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clka);
      #1;
      rst_n = 1'b1;
   endtask

   int t0, prev, got, sent_total;
   int exp_da_t1[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int order[5]     = '{0, 1, 2, 3, 0};

   initial begin
      // single requester, 8'hA5 straight out of reset
      repeat (3) @(posedge clka);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b0001;
      req_data[7:0] = 8'hA5;
      @(negedge clka);
      chk("t1_ready", 32'(req_ready), 32'h1);
      t0 = cyc;
      step;
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clka);
         chk("t1_wra_low", 32'(wra_n), 0);
         chk("t1_da", 32'(da), 32'(exp_da_t1[k]));
      end
      for (int k = 0; k < G; k++) begin
         @(negedge clka);
         chk("t1_gap_wra", 32'(wra_n), 1);
         chk("t1_gap_busy", 32'(busy), 1);
      end
      @(negedge clka);
      chk("t1_busy_fall", 32'(busy), 0);
      chk("t1_fall_cycle", 32'(cyc - t0), 15);

      // all requesters held valid: rotation and spacing
      step;
      do_reset;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'(16 + i);
      prev = 0;
      for (int g = 0; g < 5; g++) begin
         got = 0;
         for (int w = 0; w < 40 && got == 0; w++) begin
            @(negedge clka);
            if (req_ready != '0) got = 1;
         end
         chk("t2_grant_seen", 32'(got), 1);
         chk("t2_ready", 32'(req_ready), 32'(1 << order[g]));
         if (g > 0) chk("t2_spacing", 32'(cyc - prev), 15);
         prev = cyc;
         @(negedge clka);
         chk("t2_cur_id", 32'(cur_id), 32'(order[g]));
      end

      // late request during SHIFT waits for the next IDLE
      step;
      do_reset;
      req_valid = 4'b0001;
      req_data[7:0] = 8'h3C;
      @(negedge clka);
      t0 = cyc;
      step;
      req_valid = '0;
      step;
      step;
      req_valid[2] = 1'b1;
      req_data[23:16] = 8'h77;
      got = 0;
      for (int w = 0; w < 40 && got == 0; w++) begin
         @(negedge clka);
         if (req_ready != '0) got = 1;
      end
      chk("t3_grant_seen", 32'(got), 1);
      chk("t3_grant_cycle", 32'(cyc - t0), 15);
      chk("t3_ready", 32'(req_ready), 32'h4);
      step;
      req_valid = '0;

      // asynchronous abort at T+4
      do_reset;
      req_valid = 4'b0001;
      req_data[7:0] = 8'hFF;
      @(negedge clka);
      chk("t4_ready", 32'(req_ready), 32'h1);
      step;
      req_valid = '0;
      step;
      step;
      step;
      #1;
      chk("t4_mid_wra", 32'(wra_n), 0);
      chk("t4_mid_da", 32'(da), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t4_abort_wra", 32'(wra_n), 1);
      chk("t4_abort_da", 32'(da), 0);
      chk("t4_abort_busy", 32'(busy), 0);
      step;
      step;
      rst_n = 1'b1;
      req_valid = '1;
      @(negedge clka);
      chk("t4_regrant", 32'(req_ready), 32'h1);
      step;
      req_valid = '0;

      // random valids, 200 bytes through the receiver
      do_reset;
      sent_total = 0;
      for (int c = 0; c < 20000 && rx_count < 200; c++) begin
         step;
         for (int i = 0; i < NREQ; i++) begin
            if (hs_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && sent_total < 200 && $urandom_range(0, 3) == 0) begin
               req_data[i*8 +: 8] = 8'(i * 64 + sent_total % 64);
               req_valid[i] = 1'b1;
               sent_total++;
            end
         end
      end
      repeat (5) step;
      chk("t5_rx_count", 32'(rx_count), 200);
      chk("t5_leftover", 32'(sent_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
